// File: rtl/neuron_pkg.sv
// Shared types and constants for the sequential 8-input neuron.
package neuron_pkg;

    localparam int NUM_LANES    = 8;
    localparam int WIDTH_D      = 4;
    localparam int IN_WIDTH_D   = 4;
    localparam int ACC_WIDTH_D  = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Largest value an unsigned accumulator of width w can hold.
    function automatic int unsigned sat_max(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/neuron_mac_step.sv
// One multiply-accumulate step: acc + w*a, clamped to the accumulator range.
module mac_step
    import neuron_pkg::*;
#(
    parameter int WIDTH_P     = WIDTH_D,
    parameter int IN_WIDTH_P  = IN_WIDTH_D,
    parameter int ACC_WIDTH_P = ACC_WIDTH_D
) (
    input  logic [ACC_WIDTH_P-1:0] acc,
    input  logic [WIDTH_P-1:0]     w,
    input  logic [IN_WIDTH_P-1:0]  a,
    output logic [ACC_WIDTH_P-1:0] acc_next,
    output logic                   sat
);

    localparam int PROD_W = WIDTH_P + IN_WIDTH_P;
    // One spare bit above the wider operand so the carry-out is never lost.
    localparam int SUM_W  = ((ACC_WIDTH_P > PROD_W) ? ACC_WIDTH_P : PROD_W) + 1;

    logic [PROD_W-1:0] prod;
    logic [SUM_W-1:0]  sum;

    // Exact unsigned product and sum, then clamp on any bit above the accumulator.
    always_comb begin
        prod     = PROD_W'(w) * PROD_W'(a);
        sum      = SUM_W'(acc) + SUM_W'(prod);
        sat      = |sum[SUM_W-1:ACC_WIDTH_P];
        acc_next = sat ? {ACC_WIDTH_P{1'b1}} : sum[ACC_WIDTH_P-1:0];
    end

endmodule

// File: rtl/neuron_mac.sv
// Sequential 8-input neuron: snapshots weights/activations/threshold on start,
// runs one saturating MAC per cycle over lanes 0..7, then holds the result
// behind a valid/ready handshake.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int WIDTH_P     = WIDTH_D,
    parameter int IN_WIDTH_P  = IN_WIDTH_D,
    parameter int ACC_WIDTH_P = ACC_WIDTH_D
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    output logic                            start_ready_o,
    input  logic [WIDTH_P-1:0]              weight_0,
    input  logic [WIDTH_P-1:0]              weight_1,
    input  logic [WIDTH_P-1:0]              weight_2,
    input  logic [WIDTH_P-1:0]              weight_3,
    input  logic [WIDTH_P-1:0]              weight_4,
    input  logic [WIDTH_P-1:0]              weight_5,
    input  logic [WIDTH_P-1:0]              weight_6,
    input  logic [WIDTH_P-1:0]              weight_7,
    input  logic [NUM_LANES*IN_WIDTH_P-1:0] act_i,
    input  logic [ACC_WIDTH_P-1:0]          threshold_i,
    output logic [ACC_WIDTH_P-1:0]          sum_o,
    output logic                            fire_o,
    output logic                            valid_o,
    input  logic                            ready_i
);

    localparam int IDX_W = $clog2(NUM_LANES);
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_LANES - 1);
    localparam logic [ACC_WIDTH_P-1:0] ACC_MAX  = ACC_WIDTH_P'(sat_max(ACC_WIDTH_P));

    state_t                                state;
    logic [IDX_W-1:0]                      index;
    logic [ACC_WIDTH_P-1:0]                acc;
    logic                                  sat_q;
    logic [NUM_LANES-1:0][WIDTH_P-1:0]     w_in;
    logic [NUM_LANES-1:0][WIDTH_P-1:0]     w_q;
    logic [NUM_LANES-1:0][IN_WIDTH_P-1:0]  a_q;
    logic [ACC_WIDTH_P-1:0]                thr_q;

    logic [WIDTH_P-1:0]                    w_cur;
    logic [IN_WIDTH_P-1:0]                 a_cur;
    logic [ACC_WIDTH_P-1:0]                step_acc;
    logic                                  step_sat;
    logic [ACC_WIDTH_P-1:0]                acc_nxt;

    assign w_in = {weight_7, weight_6, weight_5, weight_4,
                   weight_3, weight_2, weight_1, weight_0};

    // Select the lane being accumulated this cycle; a sticky saturation
    // flag pins the accumulator at full scale once it has overflowed.
    always_comb begin
        w_cur   = w_q[index];
        a_cur   = a_q[index];
        acc_nxt = (sat_q || step_sat) ? ACC_MAX : step_acc;
    end

    mac_step #(
        .WIDTH_P     (WIDTH_P),
        .IN_WIDTH_P  (IN_WIDTH_P),
        .ACC_WIDTH_P (ACC_WIDTH_P)
    ) u_step (
        .acc      (acc),
        .w        (w_cur),
        .a        (a_cur),
        .acc_next (step_acc),
        .sat      (step_sat)
    );

    // Control FSM with snapshot registers and registered handshake outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            index         <= '0;
            acc           <= '0;
            sat_q         <= 1'b0;
            w_q           <= '0;
            a_q           <= '0;
            thr_q         <= '0;
            sum_o         <= '0;
            fire_o        <= 1'b0;
            valid_o       <= 1'b0;
            start_ready_o <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && start_ready_o) begin
                        w_q           <= w_in;
                        a_q           <= act_i;
                        thr_q         <= threshold_i;
                        acc           <= '0;
                        sat_q         <= 1'b0;
                        index         <= '0;
                        start_ready_o <= 1'b0;
                        state         <= MAC;
                    end
                end
                MAC: begin
                    acc   <= acc_nxt;
                    sat_q <= sat_q | step_sat;
                    index <= index + 1'b1;
                    if (index == LAST_IDX) begin
                        sum_o   <= acc_nxt;
                        fire_o  <= (acc_nxt >= thr_q);
                        valid_o <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    // Result held until consumed; start requests are dropped here.
                    if (ready_i) begin
                        valid_o       <= 1'b0;
                        start_ready_o <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    valid_o       <= 1'b0;
                    start_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Sequential 8-input neuron that consumes the eight weight lanes produced by the LFSR weight generator.
- On start, snapshots all eight weights, eight activations and a threshold, then computes a weighted sum with one multiply-accumulate per cycle.
- Presents the sum and a fire flag through a valid/ready output handshake.
- Sits downstream of the weight generator and upstream of the output/readout logic.

Parameters:
- WIDTH_P, 4, weight lane width (unsigned); matches the generator lanes.
- IN_WIDTH_P, 4, activation lane width (unsigned).
- ACC_WIDTH_P, 11, accumulator/sum width. The default holds the exact maximum of 8*15*15 = 1800.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous reset, active-high.
- start_i  input  1  request to begin a computation.
- start_ready_o  output  1  high only in IDLE; start accepted when start_i && start_ready_o.
- weight_0 .. weight_7  input  WIDTH_P each  weight lanes 0..7.
- act_i  input  8*IN_WIDTH_P  packed activations; lane k = act_i[k*IN_WIDTH_P +: IN_WIDTH_P].
- threshold_i  input  ACC_WIDTH_P  fire threshold.
- sum_o  output  ACC_WIDTH_P  weighted sum result.
- fire_o  output  1  sum_o >= captured threshold.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts result.

Behaviour:
- Reset is synchronous and active-high (rst_i). It is checked on every edge and overrides all other activity. Effect on the next edge:
  - state=IDLE, index=0, acc=0.
  - sum_o=0, fire_o=0, valid_o=0.
  - start_ready_o=1 after reset deasserts.
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - start_ready_o=1.
  - On accept edge: snapshot weight_0..7, act_i and threshold_i into registers; acc<=0; index<=0; go to MAC.
  - After the snapshot, input changes have no effect on the result.
- MAC:
  - start_ready_o=0.
  - Each edge: acc <= sat(acc + w[index]*a[index]); index++.
  - Products are unsigned, WIDTH_P+IN_WIDTH_P bits.
  - sat() clamps to 2^ACC_WIDTH_P - 1 when the true sum overflows. Once saturated, acc stays saturated.
  - On the edge processing index=7: go to DONE, sum_o<=final acc, fire_o<=(final acc >= threshold), valid_o<=1.
- Latency: valid_o rises on the 8th rising edge after the accept edge (exactly 8 MAC cycles).
- DONE:
  - valid_o=1; sum_o and fire_o stay stable while ready_i=0, for any number of cycles.
  - On edge with ready_i=1: valid_o<=0, go to IDLE. sum_o/fire_o keep their last values (don't-care when valid_o=0).
  - start_i in DONE is ignored; no direct DONE->MAC restart.
- start_i asserted in MAC or DONE is ignored, not queued.
- Threshold of 0 always fires. Threshold above the maximum reachable sum never fires, unless the sum saturates and the threshold equals the all-ones value.
- Reset mid-MAC or mid-DONE aborts the computation; no partial result is emitted.
- Accumulation is lane-ordered 0..7. The result is order-independent, but index is visible for debug.

Decomposition:
- Package neuron_pkg:
  - state enum (IDLE, MAC, DONE).
  - NUM_LANES=8 constant.
  - default width constants.
  - localparam function for the saturation maximum.
- Sub-module mac_step (combinational):
  - inputs: acc, w, a.
  - outputs: next acc and a saturated flag.
  - isolates the multiply and saturating add so it can be unit-tested.
- FSM, index counter and snapshot registers stay in neuron_mac.

Test Plan:
1. All weights=1, all act lanes=1, threshold=8, ready_i=1 -> valid_o high exactly 8 edges after the accept edge, sum_o=8, fire_o=1, single-cycle valid pulse, return to IDLE.
2. Weights all 15, acts all 15, threshold=1000, default ACC_WIDTH_P=11 -> sum_o=1800, fire_o=1. Rerun with ACC_WIDTH_P=10 -> sum_o=1023 (saturated), fire_o=1. Threshold=1024 is not representable at that width; use 1023 -> fire_o=1.
3. Weights w[k]=k, acts a[k]=2, threshold=57; change all weights to 0 on the cycle after accept -> sum_o=56, fire_o=0 (snapshot honoured).
4. Backpressure: ready_i=0 for 5 cycles after valid_o rises; assert start_i during MAC and DONE -> sum_o/fire_o/valid_o stable for all 5 cycles, start_ready_o=0 throughout, no second computation; ready_i=1 -> IDLE next edge.
5. Assert rst_i for one cycle when index=4 -> next edge state IDLE, valid_o=0, sum_o=0, start_ready_o=1. A fresh start with test-1 data then yields sum_o=8 after 8 edges.
6. Back-to-back: accept, consume result with ready_i=1, start_i held high -> second accept on the cycle IDLE is re-entered, second result correct, no dropped or duplicated valid pulses.
